// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
// Read-side controller for two virtual-channel FIFOs. Each cycle it pops at
// most one word, with VC0 having strict priority over VC1. The word is
// forwarded one cycle later to destination D0 or D1, chosen by bit DEST_BIT
// of the word. Destination pause flags are honoured with no bypass, so a
// paused VC0 head also blocks VC1. Any FIFO error moves the block into a
// sticky ERROR state that only reset clears.
module vc_pop_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  input  logic                 fifo_error_vc0,
  input  logic                 fifo_error_vc1,
  input  logic                 fifo_error_d0,
  input  logic                 fifo_error_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic [7:0]           pkt_count_d0,
  output logic [7:0]           pkt_count_d1,
  output logic [1:0]           state,
  output logic                 idle_out,
  output logic                 error_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 any_error_s;
  logic                 any_data_s;
  logic                 cand_valid_s;
  logic                 cand_is_vc1_s;
  logic [DATA_SIZE-1:0] head_s;
  logic                 dest_s;
  logic                 paused_s;
  logic                 grant_s;

  logic                 push_d0_r;
  logic                 push_d1_r;
  logic [DATA_SIZE-1:0] data_d0_r;
  logic [DATA_SIZE-1:0] data_d1_r;
  logic [7:0]           count_d0_r;
  logic [7:0]           count_d1_r;

  assign any_error_s = fifo_error_vc0 | fifo_error_vc1 | fifo_error_d0 | fifo_error_d1;
  assign any_data_s  = ~fifo_empty_vc0 | ~fifo_empty_vc1;

  // Candidate selection (VC0 first) and grant qualification; no bypass of a blocked VC0.
  always_comb begin
    head_s        = {DATA_SIZE{1'b0}};
    cand_valid_s  = 1'b0;
    cand_is_vc1_s = 1'b0;
    if (!fifo_empty_vc0) begin
      head_s       = data_vc0;
      cand_valid_s = 1'b1;
    end else if (!fifo_empty_vc1) begin
      head_s        = data_vc1;
      cand_valid_s  = 1'b1;
      cand_is_vc1_s = 1'b1;
    end else begin
      head_s        = {DATA_SIZE{1'b0}};
      cand_valid_s  = 1'b0;
      cand_is_vc1_s = 1'b0;
    end
    dest_s   = head_s[DEST_BIT];
    paused_s = dest_s ? fifo_pause_d1 : fifo_pause_d0;
    grant_s  = (state_r == ST_ACTIVE) && cand_valid_s && !paused_s && !any_error_s;
  end

  // Next-state logic; an error beats every other transition out of IDLE/ACTIVE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RESET: state_next_s = ST_IDLE;
      ST_IDLE: begin
        if (any_error_s) begin
          state_next_s = ST_ERROR;
        end else if (any_data_s) begin
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (any_error_s) begin
          state_next_s = ST_ERROR;
        end else if (!any_data_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      ST_ERROR: state_next_s = ST_ERROR;
      default:  state_next_s = ST_ERROR;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Forward the granted word one cycle later and count it; reset drops a pending push.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_d0_r  <= 1'b0;
      push_d1_r  <= 1'b0;
      data_d0_r  <= {DATA_SIZE{1'b0}};
      data_d1_r  <= {DATA_SIZE{1'b0}};
      count_d0_r <= 8'd0;
      count_d1_r <= 8'd0;
    end else begin
      push_d0_r <= grant_s && !dest_s;
      push_d1_r <= grant_s && dest_s;
      if (grant_s && !dest_s) begin
        data_d0_r  <= head_s;
        count_d0_r <= count_d0_r + 8'd1;
      end
      if (grant_s && dest_s) begin
        data_d1_r  <= head_s;
        count_d1_r <= count_d1_r + 8'd1;
      end
    end
  end

  assign pop_vc0      = grant_s && !cand_is_vc1_s;
  assign pop_vc1      = grant_s && cand_is_vc1_s;
  assign push_d0      = push_d0_r;
  assign push_d1      = push_d1_r;
  assign data_d0      = data_d0_r;
  assign data_d1      = data_d1_r;
  assign pkt_count_d0 = count_d0_r;
  assign pkt_count_d1 = count_d1_r;
  assign state        = state_r;
  assign idle_out     = (state_r == ST_IDLE);
  assign error_out    = (state_r == ST_ERROR);

endmodule
